// File: rtl/itag_sram_ctrl_if.sv
// ============================================================================
// Module      : itag_sram_ctrl_if
// Description : Request/grant and tag-SRAM command bundle for itag_sram_ctrl.
//               "slave" is the controller side.
//               "master" is the requester / memory-model side.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface itag_sram_ctrl_if #(
  parameter int N_WAY      = 4,
  parameter int TAG_WIDTH  = 20,
  parameter int ADDR_WIDTH = 8
);

  logic                  flush_i;
  logic                  lkp_req_i;
  logic [ADDR_WIDTH-1:0] lkp_addr_i;
  logic                  lkp_gnt_o;
  logic                  lkp_rvalid_o;
  logic                  rfl_req_i;
  logic [ADDR_WIDTH-1:0] rfl_addr_i;
  logic [N_WAY-1:0]      rfl_way_i;
  logic [TAG_WIDTH-1:0]  rfl_tag_i;
  logic                  rfl_gnt_o;
  logic                  busy_o;
  logic [N_WAY-1:0]      mem_req_o;
  logic                  mem_we_o;
  logic                  mem_vbit_o;
  logic                  mem_flush_o;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic [TAG_WIDTH-1:0]  mem_data_o;

  modport slave (
    input  flush_i, lkp_req_i, lkp_addr_i,
    input  rfl_req_i, rfl_addr_i, rfl_way_i, rfl_tag_i,
    output lkp_gnt_o, lkp_rvalid_o, rfl_gnt_o, busy_o,
    output mem_req_o, mem_we_o, mem_vbit_o, mem_flush_o, mem_addr_o, mem_data_o
  );

  modport master (
    output flush_i, lkp_req_i, lkp_addr_i,
    output rfl_req_i, rfl_addr_i, rfl_way_i, rfl_tag_i,
    input  lkp_gnt_o, lkp_rvalid_o, rfl_gnt_o, busy_o,
    input  mem_req_o, mem_we_o, mem_vbit_o, mem_flush_o, mem_addr_o, mem_data_o
  );

endinterface

`default_nettype wire

// File: rtl/itag_sram_ctrl.sv
// ============================================================================
// Module      : itag_sram_ctrl
// Description : Arbiter/sequencer for the I-cache tag SRAM port.
//               - Shares the port between lookup and refill.
//               - Flush priority is flush > refill > lookup.
//               - A set-walk invalidates every set after reset and on flush.
//               - SRAM commands are registered.
// Option      : ITAG_CTRL_STARVE_GUARD_EN
//               When defined, a lookup that has been denied MAX_STALL times
//               is granted ahead of a pending refill.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module itag_sram_ctrl #(
  parameter int N_WAY      = 4,
  parameter int TAG_WIDTH  = 20,
  parameter int ADDR_WIDTH = 8,
  parameter int DEPTH      = 256,
  parameter int MAX_STALL  = 8
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  itag_sram_ctrl_if.slave  bus
);

  typedef enum logic [0:0] {
    WALK = 1'b0,
    IDLE = 1'b1
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_SET = ADDR_WIDTH'(DEPTH - 1);

  state_t                state;
  logic [ADDR_WIDTH-1:0] walk_cnt;
  logic [ADDR_WIDTH-1:0] walk_addr;
  logic                  lkp_issued;
  logic                  lkp_rvalid;
  logic                  lkp_gnt;
  logic                  rfl_gnt;
  logic                  starve_force;
  logic [N_WAY-1:0]      mem_req;
  logic                  mem_we;
  logic                  mem_vbit;
  logic                  mem_flush;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [TAG_WIDTH-1:0]  mem_data;

`ifdef ITAG_CTRL_STARVE_GUARD_EN
  localparam int STALL_W = $clog2(MAX_STALL + 1);
  localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(MAX_STALL);

  logic [STALL_W-1:0] stall_cnt;

  assign starve_force = (stall_cnt == STALL_MAX);

  // Saturating count of denied lookups; cleared by a lookup grant or walk entry
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      stall_cnt <= '0;
    end else if (state != IDLE || bus.flush_i || lkp_gnt) begin
      stall_cnt <= '0;
    end else if (bus.lkp_req_i && stall_cnt != STALL_MAX) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end
`else
  logic unused_max_stall;

  assign starve_force     = 1'b0;
  assign unused_max_stall = (MAX_STALL > 0);
`endif

  // A flush restarts the walk at set 0.
  // Set 0 is always the walk cycle that carries the clear strobe.
  assign walk_addr = bus.flush_i ? '0 : walk_cnt;

  // Combinational arbitration: grants only in IDLE and never on a flush cycle
  always_comb begin
    lkp_gnt = 1'b0;
    rfl_gnt = 1'b0;
    if (state == IDLE && !bus.flush_i) begin
      if (bus.lkp_req_i && (starve_force || !bus.rfl_req_i)) begin
        lkp_gnt = 1'b1;
      end else if (bus.rfl_req_i) begin
        rfl_gnt = 1'b1;
      end
    end
  end

  // FSM with registered SRAM commands and lookup read-valid pipeline
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state      <= WALK;
      walk_cnt   <= '0;
      lkp_issued <= 1'b0;
      lkp_rvalid <= 1'b0;
      mem_req    <= '0;
      mem_we     <= 1'b0;
      mem_vbit   <= 1'b0;
      mem_flush  <= 1'b0;
      mem_addr   <= '0;
      mem_data   <= '0;
    end else begin
      // A lookup already issued to the SRAM returns its data even across a flush
      lkp_rvalid <= lkp_issued;
      case (state)
        WALK: begin
          mem_req    <= {N_WAY{1'b1}};
          mem_we     <= 1'b1;
          mem_vbit   <= 1'b0;
          mem_flush  <= (walk_addr == '0);
          mem_addr   <= walk_addr;
          mem_data   <= '0;
          lkp_issued <= 1'b0;
          if (walk_addr == LAST_SET) begin
            state    <= IDLE;
            walk_cnt <= '0;
          end else begin
            walk_cnt <= walk_addr + 1'b1;
          end
        end
        default: begin
          mem_req    <= '0;
          mem_we     <= 1'b0;
          mem_vbit   <= 1'b0;
          mem_flush  <= 1'b0;
          lkp_issued <= lkp_gnt;
          if (bus.flush_i) begin
            state    <= WALK;
            walk_cnt <= '0;
          end else if (rfl_gnt) begin
            mem_req  <= bus.rfl_way_i;
            mem_we   <= 1'b1;
            mem_vbit <= 1'b1;
            mem_addr <= bus.rfl_addr_i;
            mem_data <= bus.rfl_tag_i;
          end else if (lkp_gnt) begin
            mem_req  <= {N_WAY{1'b1}};
            mem_addr <= bus.lkp_addr_i;
          end
        end
      endcase
    end
  end

  assign bus.lkp_gnt_o    = lkp_gnt;
  assign bus.rfl_gnt_o    = rfl_gnt;
  assign bus.lkp_rvalid_o = lkp_rvalid;
  assign bus.busy_o       = (state == WALK);
  assign bus.mem_req_o    = mem_req;
  assign bus.mem_we_o     = mem_we;
  assign bus.mem_vbit_o   = mem_vbit;
  assign bus.mem_flush_o  = mem_flush;
  assign bus.mem_addr_o   = mem_addr;
  assign bus.mem_data_o   = mem_data;

endmodule

`default_nettype wire
